// File: rtl/fp_compare_minmax_if.sv
// Operand/result bundle for the FloPoCo float comparator: operands, predicate
// select and tag in; relation flags, min/max and tag out.
interface fp_compare_minmax_if #(
    parameter int WE    = 11,
    parameter int WF    = 16,
    parameter int TAG_W = 4
);
    localparam int W = WE + WF + 3;

    logic             in_valid;
    logic [W-1:0]     inA;
    logic [W-1:0]     inB;
    logic [2:0]       mode;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             result;
    logic             lt;
    logic             eq;
    logic             gt;
    logic             unord;
    logic [W-1:0]     out_min;
    logic [W-1:0]     out_max;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, inA, inB, mode, in_tag,
        input  out_valid, result, lt, eq, gt, unord, out_min, out_max, out_tag
    );

    modport slave (
        input  in_valid, inA, inB, mode, in_tag,
        output out_valid, result, lt, eq, gt, unord, out_min, out_max, out_tag
    );
endinterface

// File: rtl/fp_compare_minmax.sv
// Two-stage FloPoCo float comparator: run-time predicate, lt/eq/gt/unord flags
// and bit-exact min/max forwarding, with valid and tag carried alongside.
module fp_compare_minmax #(
    parameter int WE    = 11,
    parameter int WF    = 16,
    parameter int TAG_W = 4
) (
    input logic                  clk,
    input logic                  rst,
    fp_compare_minmax_if.slave   bus
);
    localparam int W  = WE + WF + 3;
    localparam int MW = WE + WF;

    localparam logic [2:0] M_EQ    = 3'b000;
    localparam logic [2:0] M_NE    = 3'b001;
    localparam logic [2:0] M_LT    = 3'b010;
    localparam logic [2:0] M_LE    = 3'b011;
    localparam logic [2:0] M_GT    = 3'b100;
    localparam logic [2:0] M_GE    = 3'b101;
    localparam logic [2:0] M_UNORD = 3'b110;

    // Signed ordinal of the non-NaN class: -inf < -normal < zero < +normal < +inf.
    function automatic logic signed [2:0] class_rank(input logic [1:0] exn, input logic sign);
        logic signed [2:0] r;
        case (exn)
            2'b01:   r = sign ? -3'sd1 : 3'sd1;
            2'b10:   r = sign ? -3'sd2 : 3'sd2;
            default: r = 3'sd0;
        endcase
        return r;
    endfunction

    function automatic logic eval_pred(input logic [2:0] m, input logic l, input logic e,
                                       input logic g, input logic u);
        logic r;
        case (m)
            M_EQ:    r = e;
            M_NE:    r = ~e;
            M_LT:    r = l;
            M_LE:    r = l | e;
            M_GT:    r = g;
            M_GE:    r = g | e;
            M_UNORD: r = u;
            default: r = ~u;
        endcase
        return r;
    endfunction

    logic [W-1:0]      a_p0;
    logic [W-1:0]      b_p0;
    logic [2:0]        mode_p0;
    logic [TAG_W-1:0]  tag_p0;
    logic signed [2:0] rank_a_p0;
    logic signed [2:0] rank_b_p0;
    logic              mag_gt_p0;
    logic              mag_eq_p0;
    logic              vld_p0;

    // Stage 1: register operands, decode class, compare {exp,frac} magnitudes
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= bus.in_valid;
        end
        a_p0      <= bus.inA;
        b_p0      <= bus.inB;
        mode_p0   <= bus.mode;
        tag_p0    <= bus.in_tag;
        rank_a_p0 <= class_rank(bus.inA[W-1:W-2], bus.inA[W-3]);
        rank_b_p0 <= class_rank(bus.inB[W-1:W-2], bus.inB[W-3]);
        mag_gt_p0 <= bus.inA[MW-1:0] > bus.inB[MW-1:0];
        mag_eq_p0 <= bus.inA[MW-1:0] == bus.inB[MW-1:0];
    end

    logic         nan_a;
    logic         nan_b;
    logic         rel_lt;
    logic         rel_eq;
    logic         rel_gt;
    logic         rel_unord;
    logic [W-1:0] sel_min;
    logic [W-1:0] sel_max;

    // Stage 2: resolve sign against magnitude, then pick min/max
    always_comb begin
        nan_a     = a_p0[W-1:W-2] == 2'b11;
        nan_b     = b_p0[W-1:W-2] == 2'b11;
        rel_lt    = 1'b0;
        rel_eq    = 1'b0;
        rel_gt    = 1'b0;
        rel_unord = 1'b0;
        if (nan_a || nan_b) begin
            rel_unord = 1'b1;
        end else if (rank_a_p0 < rank_b_p0) begin
            rel_lt = 1'b1;
        end else if (rank_a_p0 > rank_b_p0) begin
            rel_gt = 1'b1;
        end else if (rank_a_p0 == 3'sd1) begin
            rel_eq = mag_eq_p0;
            rel_gt = ~mag_eq_p0 & mag_gt_p0;
            rel_lt = ~mag_eq_p0 & ~mag_gt_p0;
        end else if (rank_a_p0 == -3'sd1) begin
            // Negative normals: larger magnitude is the smaller value
            rel_eq = mag_eq_p0;
            rel_lt = ~mag_eq_p0 & mag_gt_p0;
            rel_gt = ~mag_eq_p0 & ~mag_gt_p0;
        end else begin
            rel_eq = 1'b1;
        end

        sel_min = a_p0;
        sel_max = b_p0;
        if (nan_a && !nan_b) begin
            sel_min = b_p0;
            sel_max = b_p0;
        end else if (nan_b) begin
            sel_min = a_p0;
            sel_max = a_p0;
        end else if (rel_gt) begin
            sel_min = b_p0;
            sel_max = a_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.result    <= 1'b0;
            bus.lt        <= 1'b0;
            bus.eq        <= 1'b0;
            bus.gt        <= 1'b0;
            bus.unord     <= 1'b0;
            bus.out_min   <= '0;
            bus.out_max   <= '0;
            bus.out_tag   <= '0;
        end else begin
            bus.out_valid <= vld_p0;
            if (vld_p0) begin
                bus.result  <= eval_pred(mode_p0, rel_lt, rel_eq, rel_gt, rel_unord);
                bus.lt      <= rel_lt;
                bus.eq      <= rel_eq;
                bus.gt      <= rel_gt;
                bus.unord   <= rel_unord;
                bus.out_min <= sel_min;
                bus.out_max <= sel_max;
                bus.out_tag <= tag_p0;
            end
        end
    end
endmodule
